// File: rtl/serial_rx_align.sv
// serial_rx_align: recovers byte alignment from a serial MSB-first bit stream.
// The block hunts for the COMMA byte at any bit offset, then confirms the
// alignment over SYNC_COUNT consecutive boundary-aligned COMMAs before it
// declares lock. Once locked, every non-COMMA byte is presented on data_out
// with a one-cycle valid_out strobe. Lock is held until reset.
module serial_rx_align #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    // bc_cnt only has to reach SYNC_COUNT, so size it for exactly that range.
    localparam int BC_W = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);
    localparam logic [BC_W-1:0] BC_LOCK = BC_W'(SYNC_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          state_q;
    logic [7:0]      sr_q;
    logic [7:0]      sr_d;
    logic [2:0]      bit_cnt_q;
    logic [BC_W-1:0] bc_cnt_q;
    logic [BC_W-1:0] bc_inc;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            active_q;
    logic            boundary;
    logic            is_comma;

    // Next shift-register value and the per-edge decodes derived from it.
    always_comb begin
        sr_d     = {sr_q[6:0], data_in};
        is_comma = (sr_d == COMMA);
        boundary = (bit_cnt_q == 3'd7);
        bc_inc   = bc_cnt_q + 1'b1;
    end

    // Alignment state machine with registered outputs.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state_q   <= SEARCH;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            valid_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    // Any bit offset is a candidate; the COMMA fixes the phase.
                    if (is_comma) begin
                        bit_cnt_q <= 3'd0;
                        bc_cnt_q  <= BC_W'(1);
                        if (BC_LOCK <= BC_W'(1)) begin
                            state_q  <= ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    // Only boundary bytes count; mid-byte COMMAs are ignored.
                    if (boundary) begin
                        if (is_comma) begin
                            bc_cnt_q <= bc_inc;
                            if (bc_inc == BC_LOCK) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= SEARCH;
                            bc_cnt_q  <= '0;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    // Idle bytes leave data_out untouched and raise no strobe.
                    if (boundary && !is_comma) begin
                        data_q  <= sr_d;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= SEARCH;
                    bit_cnt_q <= 3'd0;
                    bc_cnt_q  <= '0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule
